// File: rtl/phase_sequencer.sv
// Multicycle phase sequencer for the single-issue RV32 core: one-cycle phase
// enables on the core clock, execute/memory stall handling, sticky memory
// timeout error, retired-instruction and stall-cycle counters.
module phase_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run,
  input  logic        rwmem,
  input  logic        exaluEnable,
  input  logic        memWait,
  input  logic        exBusy,
  output logic        EN_FT,
  output logic        EN_DC,
  output logic        EN_EX,
  output logic        EN_MA,
  output logic        EN_WB,
  output logic [3:0]  phase,
  output logic        busErr,
  output logic [31:0] instCount,
  output logic [31:0] stallCount
);

  localparam int unsigned PH_W = 4;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [PH_W-1:0] {
    S_IDLE = 4'd0,
    S_FT   = 4'd1,
    S_DC   = 4'd2,
    S_EX   = 4'd3,
    S_EXW  = 4'd4,
    S_MA   = 4'd5,
    S_MAW  = 4'd6,
    S_WB   = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TO_W-1:0] to_cnt;
  logic            stall_cyc;

  assign stall_cyc = ((state == S_EXW) && exBusy) || ((state == S_MAW) && memWait);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run) state_nx = S_FT;
      S_FT:   state_nx = S_DC;
      S_DC:   state_nx = S_EX;
      S_EX: begin
        if (exaluEnable)  state_nx = S_EXW;
        else if (rwmem)   state_nx = S_MA;
        else              state_nx = S_WB;
      end
      S_EXW: begin
        if (!exBusy) state_nx = rwmem ? S_MA : S_WB;
      end
      S_MA:   state_nx = S_MAW;
      S_MAW: begin
        if (!memWait)               state_nx = S_WB;
        else if (to_cnt == TO_LAST) state_nx = S_ERR;
      end
      S_WB:   state_nx = run ? S_FT : S_IDLE;
      S_ERR:  state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered Moore outputs, decoded from the state being entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      EN_FT  <= 1'b0;
      EN_DC  <= 1'b0;
      EN_EX  <= 1'b0;
      EN_MA  <= 1'b0;
      EN_WB  <= 1'b0;
      phase  <= 4'd0;
      busErr <= 1'b0;
    end else begin
      EN_FT  <= (state_nx == S_FT);
      EN_DC  <= (state_nx == S_DC);
      EN_EX  <= (state_nx == S_EX);
      EN_MA  <= (state_nx == S_MA);
      EN_WB  <= (state_nx == S_WB);
      phase  <= state_nx;
      busErr <= busErr | (state_nx == S_ERR);
    end
  end

  // Memory-wait timeout counter, cleared on entry to the wait phase
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt <= '0;
    end else if (state == S_MA) begin
      to_cnt <= '0;
    end else if ((state == S_MAW) && memWait) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Retired-instruction and stall-cycle counters, wrapping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instCount  <= 32'd0;
      stallCount <= 32'd0;
    end else begin
      if (state == S_WB) instCount  <= instCount + 32'd1;
      if (stall_cyc)     stallCount <= stallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: table of instruction shapes with hand-derived
// latencies, random instruction mix against a phase-list model, timeout and
// asynchronous-reset corner cases.
module tb_phase_sequencer;

  localparam int MEM_TO = 4;
  localparam int P_IDLE = 0, P_FT = 1, P_DC = 2, P_EX = 3, P_EXW = 4,
                 P_MA = 5, P_MAW = 6, P_WB = 7, P_ERR = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        run, rwmem, exaluEnable, memWait, exBusy;
  logic        EN_FT, EN_DC, EN_EX, EN_MA, EN_WB;
  logic [3:0]  phase;
  logic        busErr;
  logic [31:0] instCount, stallCount;

  int total = 0;
  int bad   = 0;
  int m_inst = 0;
  int m_stall = 0;

  phase_sequencer #(.MEM_TIMEOUT(MEM_TO), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .run(run), .rwmem(rwmem), .exaluEnable(exaluEnable),
    .memWait(memWait), .exBusy(exBusy), .EN_FT(EN_FT), .EN_DC(EN_DC),
    .EN_EX(EN_EX), .EN_MA(EN_MA), .EN_WB(EN_WB), .phase(phase),
    .busErr(busErr), .instCount(instCount), .stallCount(stallCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] en_of(input int p);
    case (p)
      P_FT:    return 5'b10000;
      P_DC:    return 5'b01000;
      P_EX:    return 5'b00100;
      P_MA:    return 5'b00010;
      P_WB:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk_cycle(input int p);
    chk("phase", 32'(phase), 32'(p));
    chk("en", 32'({EN_FT, EN_DC, EN_EX, EN_MA, EN_WB}), 32'(en_of(p)));
    chk("busErr", 32'(busErr), 32'(p == P_ERR));
    chk("instCount", instCount, 32'(m_inst));
    chk("stallCount", stallCount, 32'(m_stall));
  endtask

  // Reset asynchronously from a negedge, check outputs before any clock edge,
  // then release with run=1 so the next edge enters fetch.
  task automatic async_reset();
    #2 RST = 1'b0;
    #1;
    m_inst = 0;
    m_stall = 0;
    chk_cycle(P_IDLE);
    @(negedge CLK);
    chk_cycle(P_IDLE);
    RST = 1'b1;
    run = 1'b1;
    @(negedge CLK);
  endtask

  // Runs one instruction starting in the FT cycle (at a negedge). The model is
  // the phase list the instruction must walk through.
  task automatic do_inst(input bit rw, input bit ex, input int busy, input int wt,
                         input bit run_next, input int abort_at, output int wb_at);
    int seq[$];
    int exw_n, maw_n, s;
    bit err;
    seq = {};
    wb_at = -1;
    err = (rw && wt >= MEM_TO);
    seq.push_back(P_FT); seq.push_back(P_DC); seq.push_back(P_EX);
    if (ex) for (int i = 0; i <= busy; i++) seq.push_back(P_EXW);
    if (rw) begin
      seq.push_back(P_MA);
      if (err) begin
        for (int i = 0; i < MEM_TO; i++) seq.push_back(P_MAW);
        seq.push_back(P_ERR);
      end else begin
        for (int i = 0; i <= wt; i++) seq.push_back(P_MAW);
      end
    end
    if (!err) seq.push_back(P_WB);
    exw_n = 0;
    maw_n = 0;
    for (int idx = 0; idx < seq.size(); idx++) begin
      s = seq[idx];
      chk_cycle(s);
      if (EN_WB && wb_at < 0) wb_at = idx;
      if (idx == abort_at) begin
        async_reset();
        return;
      end
      run         = (idx < 2) ? 1'b1 : run_next;
      rwmem       = (s == P_FT) ? 1'($urandom) : rw;
      exaluEnable = (s == P_FT) ? 1'($urandom) : ex;
      exBusy      = (s == P_EXW) ? (exw_n < busy) : 1'($urandom);
      memWait     = (s == P_MAW) ? (maw_n < wt) : 1'($urandom);
      if (s == P_EXW) begin
        if (exBusy) m_stall++;
        exw_n++;
      end
      if (s == P_MAW) begin
        if (memWait) m_stall++;
        maw_n++;
      end
      if (s == P_WB) m_inst++;
      @(negedge CLK);
    end
    // After WB with run low the sequencer idles; restart it.
    if (!err && !run_next) begin
      chk_cycle(P_IDLE);
      run = 1'b1;
      @(negedge CLK);
    end
  endtask

  typedef struct {
    bit rw;
    bit ex;
    int busy;
    int wt;
    bit run_next;
    int exp_wb;
    int exp_stall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int wb_at, i0, s0;
    vecs = '{
      '{0, 0, 0, 0, 1, 3, 0},
      '{0, 0, 0, 0, 1, 3, 0},
      '{0, 0, 0, 0, 1, 3, 0},
      '{1, 0, 0, 3, 1, 8, 3},
      '{1, 1, 2, 0, 1, 8, 2},
      '{1, 0, 0, 0, 1, 5, 0},
      '{0, 1, 0, 0, 1, 4, 0},
      '{0, 1, 1, 0, 0, 5, 1},
      '{1, 1, 1, 2, 1, 9, 3},
      '{0, 0, 0, 0, 0, 3, 0}
    };
    RST = 1'b0; run = 1'b0; rwmem = 1'b0; exaluEnable = 1'b0;
    memWait = 1'b0; exBusy = 1'b0;
    #3;
    chk_cycle(P_IDLE);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_cycle(P_IDLE);
    @(negedge CLK);
    chk_cycle(P_IDLE);
    run = 1'b1;
    @(negedge CLK);

    // Table of instruction shapes with hand-derived WB position and stalls
    foreach (vecs[k]) begin
      i0 = m_inst;
      s0 = m_stall;
      do_inst(vecs[k].rw, vecs[k].ex, vecs[k].busy, vecs[k].wt,
              vecs[k].run_next, -1, wb_at);
      chk("wb_latency", 32'(wb_at), 32'(vecs[k].exp_wb));
      chk("inst_delta", instCount - 32'(i0), 32'd1);
      chk("stall_delta", stallCount - 32'(s0), 32'(vecs[k].exp_stall));
    end

    // Random instruction mix
    for (int n = 0; n < 60; n++) begin
      do_inst(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, MEM_TO - 1)), 1'($urandom), -1, wb_at);
    end

    // Memory timeout: error is sticky and ignores run
    do_inst(1'b1, 1'b0, 0, MEM_TO + 2, 1'b1, -1, wb_at);
    run = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk_cycle(P_ERR);
      @(negedge CLK);
    end
    async_reset();

    // Reset in the middle of a memory wait aborts without a writeback
    do_inst(1'b1, 1'b0, 0, 3, 1'b1, 5, wb_at);
    chk("abort_no_wb", 32'(wb_at), 32'hffffffff);
    do_inst(0, 0, 0, 0, 1'b1, -1, wb_at);
    chk("restart_wb", 32'(wb_at), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
